// File: rtl/wresp_chan_mngr.sv
// wresp_chan_mngr: manager end of an AXI-style write response channel.
//
// Tracks which write IDs are outstanding, drives bready, and retires the ID
// returned on each B-channel handshake. Every retirement produces a one-cycle
// finish pulse carrying the returned ID back to the write-request side.
//
// Optional build macro: WRESP_TIMEOUT_EN adds a response-wait watchdog that
// raises resp_tout after TIMEOUT_CYC cycles of waiting in RespMwait. Without
// the macro resp_tout is tied low; the port list is identical in both builds.
//
// Parameters:
//   MAX_OUTSTD   maximum simultaneously outstanding IDs (1..16)
//   TIMEOUT_CYC  watchdog limit in cycles (8-bit compare, macro builds only)
//
// Ports:
//   clk, rst_n           clock (posedge) and asynchronous active-low reset
//   bvalid/bready        B-channel handshake (bready is a registered-state decode)
//   bid, bcomp           response ID and completion status (1 = OK)
//   wreq_m_valid/_id     burst issue from the write-request side
//   wreq_m_ready         issue accepted this cycle (combinational)
//   finish_mwr           one-cycle pulse, a response was retired
//   finish_mid           ID of the most recently retired response
//   resp_err             sticky: unexpected bid or bcomp=0
//   err_clr              clears resp_err and resp_tout
//   outstd_cnt           number of outstanding IDs
//   resp_tout            sticky watchdog flag
module wresp_chan_mngr #(
  parameter int unsigned MAX_OUTSTD  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bvalid,
  output logic       bready,
  input  logic [3:0] bid,
  input  logic       bcomp,
  input  logic       wreq_m_valid,
  input  logic [3:0] wreq_m_id,
  output logic       wreq_m_ready,
  output logic       finish_mwr,
  output logic [3:0] finish_mid,
  output logic       resp_err,
  input  logic       err_clr,
  output logic [4:0] outstd_cnt,
  output logic       resp_tout
);

  typedef enum logic [1:0] {
    RespMidle = 2'b00,
    RespMwait = 2'b01,
    RespMfin  = 2'b10,
    RespMdefo = 2'b11
  } state_e;

  localparam logic [4:0] MaxCnt = 5'(MAX_OUTSTD);

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  finish_mid_q, finish_mid_d;
  logic        resp_err_q, resp_err_d;

  logic issue;
  logic hs;
  logic retire_hit;
  logic err_set;

  // ---------------------------------------------------------------------------
  // Handshake decode. Both ready terms come from registers only, so an ID that
  // is being retired this cycle still reads as pending and cannot be reissued.
  // ---------------------------------------------------------------------------
  assign wreq_m_ready = (cnt_q < MaxCnt) & ~pending_q[wreq_m_id];
  assign issue        = wreq_m_valid & wreq_m_ready;

  assign bready       = (state_q == RespMwait);
  assign finish_mwr   = (state_q == RespMfin);
  assign hs           = bvalid & bready;

  // Only a known ID retires; an unknown one leaves count and pending alone.
  assign retire_hit   = hs & pending_q[bid];
  assign err_set      = hs & (~pending_q[bid] | ~bcomp);

  // ---------------------------------------------------------------------------
  // Outstanding-ID tracking and response bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d    = pending_q;
    finish_mid_d = finish_mid_q;
    resp_err_d   = resp_err_q;

    if (retire_hit) begin
      pending_d[bid] = 1'b0;
    end
    // Cannot collide with the retire above: a pending ID is never issuable.
    if (issue) begin
      pending_d[wreq_m_id] = 1'b1;
    end

    if (hs) begin
      finish_mid_d = bid;
    end

    // Setting wins over clearing so an error in the clear cycle is not lost.
    if (err_set) begin
      resp_err_d = 1'b1;
    end else if (err_clr) begin
      resp_err_d = 1'b0;
    end
  end

  // Issue and retire in the same cycle cancel out. Ready gating keeps the
  // count at or below MAX_OUTSTD, and a retire needs a set pending bit, so the
  // count can neither overflow nor underflow.
  assign cnt_d = cnt_q + 5'(issue) - 5'(retire_hit);

  // ---------------------------------------------------------------------------
  // Response FSM. RespMwait is the only state with bready high; RespMfin
  // separates handshakes, which limits throughput to one response per two
  // cycles and gives a one-cycle handshake-to-finish latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RespMidle: begin
        // Uses the post-update count so an issue this cycle opens bready next.
        if (cnt_d != 5'd0) begin
          state_d = RespMwait;
        end
      end
      RespMwait: begin
        if (hs) begin
          state_d = RespMfin;
        end
      end
      RespMfin: begin
        state_d = (cnt_d != 5'd0) ? RespMwait : RespMidle;
      end
      RespMdefo: begin
        state_d = RespMidle;
      end
      default: begin
        state_d = RespMidle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RespMidle;
      pending_q    <= '0;
      cnt_q        <= '0;
      finish_mid_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      finish_mid_q <= finish_mid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign outstd_cnt = cnt_q;
  assign finish_mid = finish_mid_q;
  assign resp_err   = resp_err_q;

  // ---------------------------------------------------------------------------
  // Response-wait watchdog
  // ---------------------------------------------------------------------------
`ifdef WRESP_TIMEOUT_EN
  localparam logic [7:0] ToutLim = 8'(TIMEOUT_CYC);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       resp_tout_q, resp_tout_d;
  logic       tout_hit;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q == RespMidle) || hs) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == RespMwait) && (wait_cnt_q != ToutLim)) begin
      // Saturates at the limit so the flag condition stays stable while waiting.
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Flag rises in the same edge the counter reaches the limit.
  assign tout_hit = (state_q == RespMwait) && !hs && (wait_cnt_d == ToutLim);

  always_comb begin
    resp_tout_d = resp_tout_q;
    if (tout_hit) begin
      resp_tout_d = 1'b1;
    end else if (err_clr) begin
      resp_tout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      resp_tout_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      resp_tout_q <= resp_tout_d;
    end
  end

  assign resp_tout = resp_tout_q;
`else
  // Watchdog absent: the limit parameter has no consumer in this build.
  logic unused_tout_cfg;
  assign unused_tout_cfg = (TIMEOUT_CYC != 0);
  assign resp_tout       = 1'b0;
`endif

endmodule

// File: tb/tb_wresp_chan_mngr.sv
// Self-checking bench for wresp_chan_mngr: cycle-vector table for the main
// flows, hand-written sequences for reset and watchdog, and a scoreboard that
// matches every B handshake to the finish pulse one cycle later.
module tb_wresp_chan_mngr;

  logic       clk;
  logic       rst_n;
  logic       bvalid;
  logic       bready;
  logic [3:0] bid;
  logic       bcomp;
  logic       wreq_m_valid;
  logic [3:0] wreq_m_id;
  logic       wreq_m_ready;
  logic       finish_mwr;
  logic [3:0] finish_mid;
  logic       resp_err;
  logic       err_clr;
  logic [4:0] outstd_cnt;
  logic       resp_tout;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  wresp_chan_mngr #(
    .MAX_OUTSTD (4),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bvalid      (bvalid),
    .bready      (bready),
    .bid         (bid),
    .bcomp       (bcomp),
    .wreq_m_valid(wreq_m_valid),
    .wreq_m_id   (wreq_m_id),
    .wreq_m_ready(wreq_m_ready),
    .finish_mwr  (finish_mwr),
    .finish_mid  (finish_mid),
    .resp_err    (resp_err),
    .err_clr     (err_clr),
    .outstd_cnt  (outstd_cnt),
    .resp_tout   (resp_tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: a handshake seen this cycle must yield finish_mwr with the same
  // ID exactly one cycle later.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  id;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (finish_mwr) begin
        if (sb_q.size() == 0) begin
          chk("sb_spurious_finish", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_finish_mid", 32'(finish_mid), 32'(e.id));
          chk("sb_latency", cyc - e.cyc, 32'd1);
        end
      end
      if (bvalid && bready) begin
        e.cyc = cyc;
        e.id  = bid;
        sb_q.push_back(e);
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Cycle vectors: inputs for one cycle and the outputs expected in it
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       wv;
    logic [3:0] wid;
    logic       bv;
    logic [3:0] bid;
    logic       bc;
    logic       clr;
    logic       e_wr;
    logic       e_br;
    logic       e_fin;
    logic [4:0] e_cnt;
    logic       e_err;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic wv, input logic [3:0] wid, input logic bv,
                              input logic [3:0] b, input logic bc, input logic clr,
                              input logic e_wr, input logic e_br, input logic e_fin,
                              input logic [4:0] e_cnt, input logic e_err);
    vec_t v;
    v.wv = wv; v.wid = wid; v.bv = bv; v.bid = b; v.bc = bc; v.clr = clr;
    v.e_wr = e_wr; v.e_br = e_br; v.e_fin = e_fin; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic idle_inputs();
    wreq_m_valid = 1'b0; wreq_m_id = 4'd0;
    bvalid = 1'b0; bid = 4'd0; bcomp = 1'b1; err_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    idle_inputs();

    // Single write
    vecs.push_back(mk(1, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 3, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // Fill limit, hold id 5, retire 1, then drain
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 1, 1, 0, 2, 0));
    vecs.push_back(mk(1, 3, 0, 0, 1, 0, 1, 1, 0, 3, 0));
    vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 1, 0, 4, 0));
    vecs.push_back(mk(1, 5, 1, 1, 1, 0, 0, 1, 0, 4, 0));
    vecs.push_back(mk(1, 5, 0, 0, 1, 0, 1, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 2, 1, 0, 1, 1, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 3, 1, 0, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 5, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // Duplicate issue, and issue of the ID being retired
    vecs.push_back(mk(1, 7, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 7, 1, 7, 1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 7, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 7, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // Unknown ID, failed completion, clear, set-over-clear priority
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 9, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 4, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));

    // Reset values
    #2;
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_finish_mwr", 32'(finish_mwr), 32'd0);
    chk("rst_finish_mid", 32'(finish_mid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_tout", 32'(resp_tout), 32'd0);
    chk("rst_outstd_cnt", 32'(outstd_cnt), 32'd0);
    #26 rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      v = vecs[i];
      wreq_m_valid = v.wv; wreq_m_id = v.wid;
      bvalid = v.bv; bid = v.bid; bcomp = v.bc; err_clr = v.clr;
      #1;
      chk($sformatf("vec%0d wreq_m_ready", i), 32'(wreq_m_ready), 32'(v.e_wr));
      chk($sformatf("vec%0d bready", i), 32'(bready), 32'(v.e_br));
      chk($sformatf("vec%0d finish_mwr", i), 32'(finish_mwr), 32'(v.e_fin));
      chk($sformatf("vec%0d outstd_cnt", i), 32'(outstd_cnt), 32'(v.e_cnt));
      chk($sformatf("vec%0d resp_err", i), 32'(resp_err), 32'(v.e_err));
      chk($sformatf("vec%0d resp_tout", i), 32'(resp_tout), 32'd0);
      step();
    end
    idle_inputs();

    // Reset mid-operation: three IDs outstanding, bvalid high
    for (int k = 1; k <= 3; k++) begin
      wreq_m_valid = 1'b1; wreq_m_id = 4'(k);
      step();
    end
    wreq_m_valid = 1'b0; wreq_m_id = 4'd1;
    bvalid = 1'b1; bid = 4'd1;
    #1;
    chk("mid_pre_cnt", 32'(outstd_cnt), 32'd3);
    chk("mid_pre_bready", 32'(bready), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_bready", 32'(bready), 32'd0);
    chk("mid_rst_cnt", 32'(outstd_cnt), 32'd0);
    chk("mid_rst_pending_clr", 32'(wreq_m_ready), 32'd1);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    // bvalid still held with bid=1, nothing pending: no handshake possible
    chk("post_rst_bready", 32'(bready), 32'd0);
    chk("post_rst_cnt", 32'(outstd_cnt), 32'd0);
    wreq_m_valid = 1'b1; wreq_m_id = 4'd6;
    #1;
    chk("post_rst_issue_ready", 32'(wreq_m_ready), 32'd1);
    step();
    wreq_m_valid = 1'b0;
    chk("post_rst_bready_open", 32'(bready), 32'd1);
    chk("post_rst_cnt1", 32'(outstd_cnt), 32'd1);
    step();
    bvalid = 1'b0;
    chk("post_rst_unknown_err", 32'(resp_err), 32'd1);
    chk("post_rst_unknown_cnt", 32'(outstd_cnt), 32'd1);
    chk("post_rst_unknown_fin", 32'(finish_mwr), 32'd1);
    step();
    bvalid = 1'b1; bid = 4'd6;
    chk("post_rst_bready2", 32'(bready), 32'd1);
    step();
    bvalid = 1'b0;
    chk("post_rst_retire_cnt", 32'(outstd_cnt), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("post_rst_err_clr", 32'(resp_err), 32'd0);
    step();

`ifdef WRESP_TIMEOUT_EN
    // Watchdog: response withheld for TIMEOUT_CYC cycles in the wait state
    wreq_m_valid = 1'b1; wreq_m_id = 4'd1;
    step();
    wreq_m_valid = 1'b0;
    repeat (9) step();
    chk("tout_before_limit", 32'(resp_tout), 32'd0);
    step();
    chk("tout_at_limit", 32'(resp_tout), 32'd1);
    bvalid = 1'b1; bid = 4'd1;
    step();
    bvalid = 1'b0;
    chk("tout_after_late_resp", 32'(resp_tout), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    chk("tout_cleared", 32'(resp_tout), 32'd0);
`endif

    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wresp_chan_mngr.md
Name: wresp_chan_mngr

Overview:
- Manager (initiator) end of the AXI-style write response channel.
- Records the IDs of issued write bursts and drives bready.
- Accepts bvalid/bid/bcomp from the subordinate, retires the matching outstanding ID, and returns a one-cycle finish pulse with the ID to the write-request side.
- Flags unexpected IDs and failed completions.

Parameters:
- MAX_OUTSTD, 4: maximum simultaneously outstanding write IDs; legal range 1..16.
- TIMEOUT_CYC, 255: response-wait watchdog limit in cycles. Used only with WRESP_TIMEOUT_EN; 8-bit compare.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- bvalid  input  1  response valid from subordinate.
- bready  output  1  manager ready for response.
- bid  input  4  response ID.
- bcomp  input  1  completion status; 1 = OK.
- wreq_m_valid  input  1  write request side issues a burst this cycle.
- wreq_m_id  input  4  ID of the issued burst.
- wreq_m_ready  output  1  issue accepted (combinational).
- finish_mwr  output  1  one-cycle pulse: a response was retired.
- finish_mid  output  4  ID of the last retired response.
- resp_err  output  1  sticky: unexpected bid or bcomp=0.
- err_clr  input  1  clears resp_err and resp_tout.
- outstd_cnt  output  5  number of outstanding IDs.
- resp_tout  output  1  sticky watchdog flag.

Behaviour:
Reset values (asynchronous):
- bready=0, finish_mwr=0, finish_mid=0, resp_err=0, resp_tout=0, outstd_cnt=0.
- pending[15:0]=0; state RESP_MIDLE.

Issue path:
- wreq_m_ready = (outstd_cnt < MAX_OUTSTD) & ~pending[wreq_m_id].
- Both terms use registered values only.
- Issue fires on wreq_m_valid & wreq_m_ready: set pending[wreq_m_id] and increment the count.
- A request with wreq_m_ready=0 is ignored; the requester holds it.

State machine (2-bit encoding):
- RESP_MIDLE (00):
  - bready=0.
  - Go to RESP_MWAIT when the count after this cycle's update is >0.
- RESP_MWAIT (01):
  - bready=1.
  - On bvalid (handshake), go to RESP_MFIN.
  - Otherwise stay.
- RESP_MFIN (10):
  - bready=0; finish_mwr=1 for exactly this cycle.
  - Next state RESP_MWAIT if count>0, else RESP_MIDLE.
- RESP_MDEFO (11):
  - Illegal encoding; bready=0.
  - Next state RESP_MIDLE.
  - Any unknown decode also goes to RESP_MIDLE.
- Throughput: at most one response per 2 cycles.
- Handshake-to-finish latency: 1 cycle.

Retire on handshake (bvalid & bready):
- Latch finish_mid <= bid.
- If pending[bid]=1: clear it and decrement the count.
- If pending[bid]=0: count and pending are unchanged; set resp_err.
- If bcomp=0: set resp_err; the ID is still retired normally.
- resp_err set has priority over err_clr in the same cycle.

Simultaneous events:
- Issue and retire in the same cycle: count is net unchanged.
- Issue of the ID being retired in the same cycle: rejected, because pending is still 1 that cycle.
- Count never wraps. The ready gating prevents overflow; a decrement when the count is 0 is impossible because pending is then all zero.

Reset mid-operation:
- All pending IDs are discarded.
- Any response the subordinate presents after reset is accepted only when the count is >0; an unknown ID sets resp_err.

Optional Feature:
- Macro: WRESP_TIMEOUT_EN.
- With the macro:
  - 8-bit wait counter.
  - Increments each cycle in RESP_MWAIT without a handshake.
  - Clears on handshake or in RESP_MIDLE.
  - Saturates at TIMEOUT_CYC.
  - Sets resp_tout when the counter equals TIMEOUT_CYC; resp_tout is sticky until err_clr.
- Without the macro: no counter; resp_tout tied 0. The port list is unchanged.

Test Plan:
- Single write:
  - Stimulus: issue id=3; subordinate asserts bvalid, bid=3, bcomp=1 two cycles later.
  - Response: bready=1 from the cycle after issue; finish_mwr pulses 1 cycle after handshake with finish_mid=3; outstd_cnt 1->0; back to RESP_MIDLE; resp_err=0.
- Fill limit:
  - Stimulus: MAX_OUTSTD=4; issue ids 0,1,2,3 back-to-back, then hold id=5.
  - Response: wreq_m_ready=0 for id=5 while outstd_cnt=4; retiring bid=1 makes wreq_m_ready=1 the next cycle.
- Duplicate and same-cycle issue:
  - Stimulus: id=7 outstanding; issue id=7 again, including in the cycle id=7 is being retired.
  - Response: both rejected; issuing id=7 one cycle later is accepted.
- Error cases:
  - Stimulus: response bid=9 with nothing pending; then a valid bid=2 with bcomp=0.
  - Response: resp_err=1 after the first; outstd_cnt unchanged; bid=2 still retired; err_clr clears resp_err.
- Reset mid-operation:
  - Stimulus: 3 IDs outstanding and bvalid high when rst_n is pulsed low.
  - Response: bready=0, outstd_cnt=0, pending cleared immediately; state RESP_MIDLE.
- Timeout (WRESP_TIMEOUT_EN, TIMEOUT_CYC=10):
  - Stimulus: issue id=1; bvalid withheld.
  - Response: resp_tout=1 ten cycles into RESP_MWAIT; stays set after a late response until err_clr.
